mux_nway_arb: RTL and testbench

Parametrised, registered N-way multiplexer with per-channel valid/ready handshakes and two selection modes: externally selected channel, or round-robin arbitration. It supersedes the fixed 8-way/16-bit combinational multiplexer wherever several producers share one registered consumer path. Typical producers are the ALU result, memory read data and I/O ports. The block holds one output word and applies backpressure to producers.

---
 rtl/mux_nway_arb_if.sv | 27 ++
 rtl/mux_nway_arb.sv | 75 +++++++
 tb/tb_mux_nway_arb.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_nway_arb_if.sv
// Handshake bundle between producers, the N-way arbiter/mux and its single consumer.
// Producers and the consumer attach through the master modport; the arbiter uses the slave modport.
interface mux_nway_arb_if #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 8,
    parameter int SELW  = $clog2(WAYS)
);
    logic [WAYS*WIDTH-1:0] in_data;
    logic [WAYS-1:0]       in_valid;
    logic [WAYS-1:0]       in_ready;
    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [WIDTH-1:0]      out_data;
    logic [SELW-1:0]       out_sel;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_nway_arb.sv
// Registered N-way multiplexer: fixed-select or round-robin grant into a one-word output slot
// with valid/ready backpressure toward every producer.
module mux_nway_arb #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 8
) (
    input logic             clk,
    input logic             rst_n,
    mux_nway_arb_if.slave   bus
);
    localparam int SELW = $clog2(WAYS);

    logic [WIDTH-1:0] data_p1;
    logic [SELW-1:0]  sel_p1;
    logic             vld_p1;
    logic [SELW-1:0]  ptr;

    logic             free;
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic             xfer;
    logic [WAYS-1:0]  ready;
    int               idx;

    assign free = !vld_p1 || bus.out_ready;
    assign xfer = free && grant_valid;

    // Grant selection; the downward loop leaves the nearest valid channel at/after ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        if (bus.mode) begin
            for (int k = WAYS - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= WAYS) idx = idx - WAYS;
                if (bus.in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant       = SELW'(idx);
                end
            end
        end else if (int'(bus.sel) < WAYS) begin
            grant_valid = bus.in_valid[bus.sel];
            grant       = bus.sel;
        end
    end

    always_comb begin
        ready = '0;
        if (rst_n && xfer) ready[grant] = 1'b1;
    end

    assign bus.in_ready = ready;

    // Stage p1: output slot and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            sel_p1  <= '0;
            vld_p1  <= 1'b0;
            ptr     <= '0;
        end else if (xfer) begin
            data_p1 <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
            sel_p1  <= grant;
            vld_p1  <= 1'b1;
            if (bus.mode) ptr <= (int'(grant) == WAYS - 1) ? '0 : grant + SELW'(1);
        end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.out_data  = data_p1;
    assign bus.out_sel   = sel_p1;
    assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_mux_nway_arb.sv
// Bench for mux_nway_arb: vector tables and hand sequences on 8-way and 5-way instances,
// then randomized traffic against an abstract reference model of the 8-way instance.
module tb_mux_nway_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_nway_arb_if #(.WIDTH(16), .WAYS(8)) bus8();
    mux_nway_arb_if #(.WIDTH(16), .WAYS(5)) bus5();

    mux_nway_arb #(.WIDTH(16), .WAYS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    mux_nway_arb #(.WIDTH(16), .WAYS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
    } fx_vec_t;

    fx_vec_t fx_tbl[8];
    int      rr_tbl[10];
    int      ab_tbl[4];
    int      w5_tbl[7];

    logic        m_vld;
    logic [15:0] m_data;
    int          m_sel;
    int          m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Grant rule written straight from the selection rules; -1 means no grant.
    function automatic int pick(input logic [7:0] v, input logic md, input int s,
                                input int p, input int ways);
        if (md) begin
            for (int i = 0; i < ways; i++) begin
                int j;
                j = (p + i) % ways;
                if (v[j]) return j;
            end
            return -1;
        end
        if (s < ways && v[s]) return s;
        return -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vals [8];
        logic [7:0]  exp_rdy;
        int          g;
        logic        fr;

        vals = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h789A, 16'h89AB};
        for (int i = 0; i < 8; i++) begin
            fx_tbl[i].sel  = 3'(i);
            fx_tbl[i].data = vals[i];
        end
        rr_tbl = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        ab_tbl = '{2, 5, 2, 5};
        w5_tbl = '{0, 1, 2, 3, 4, 0, 1};

        bus8.in_data = '0; bus8.in_valid = '0; bus8.mode = 1'b0; bus8.sel = '0; bus8.out_ready = 1'b0;
        bus5.in_data = '0; bus5.in_valid = '0; bus5.mode = 1'b0; bus5.sel = '0; bus5.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus8.in_data[i*16 +: 16] = vals[i];
        for (int i = 0; i < 5; i++) bus5.in_data[i*16 +: 16] = 16'hA000 + 16'(i);

        repeat (2) tick();
        check("rst_out_valid", 32'(bus8.out_valid), 0);
        check("rst_out_data", 32'(bus8.out_data), 0);
        check("rst_out_sel", 32'(bus8.out_sel), 0);
        rst_n = 1'b1;
        tick();

        // Fixed-mode sweep
        bus8.in_valid = 8'hFF; bus8.out_ready = 1'b1; bus8.mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus8.sel = fx_tbl[i].sel;
            #1;
            check("fx_in_ready", 32'(bus8.in_ready), 32'(8'(1) << i));
            tick();
            check("fx_out_data", 32'(bus8.out_data), 32'(fx_tbl[i].data));
            check("fx_out_sel", 32'(bus8.out_sel), 32'(fx_tbl[i].sel));
            check("fx_out_valid", 32'(bus8.out_valid), 1);
        end

        // Round-robin, all valid, back-to-back
        bus8.mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rr_out_sel", 32'(bus8.out_sel), 32'(rr_tbl[i]));
            check("rr_out_valid", 32'(bus8.out_valid), 1);
        end

        // Asynchronous reset with a held word and all producers valid
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus8.out_valid), 0);
        check("arst_out_data", 32'(bus8.out_data), 0);
        check("arst_out_sel", 32'(bus8.out_sel), 0);
        check("arst_in_ready", 32'(bus8.in_ready), 0);
        tick();
        check("arst_in_ready_hold", 32'(bus8.in_ready), 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus8.in_ready), 32'h1);
        tick();
        check("post_rst_out_sel", 32'(bus8.out_sel), 0);
        check("post_rst_out_valid", 32'(bus8.out_valid), 1);

        // Round-robin with only channels 2 and 5
        bus8.in_valid = 8'b0010_0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ab_out_sel", 32'(bus8.out_sel), 32'(ab_tbl[i]));
        end
        bus8.in_valid = 8'b0000_0100;
        tick();
        check("ab_drop5_out_sel", 32'(bus8.out_sel), 2);

        // Backpressure
        bus8.in_valid = 8'hFF; bus8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(bus8.in_ready), 0);
            tick();
            check("bp_out_data", 32'(bus8.out_data), 32'h3456);
            check("bp_out_sel", 32'(bus8.out_sel), 2);
            check("bp_out_valid", 32'(bus8.out_valid), 1);
        end
        bus8.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(bus8.in_ready), 32'h08);
        tick();
        check("bp_release_out_sel", 32'(bus8.out_sel), 3);
        check("bp_release_out_data", 32'(bus8.out_data), 32'h4567);

        // Mode switch after RR granted channel 3
        bus8.mode = 1'b0; bus8.sel = 3'd1;
        #1;
        check("ms_fixed_in_ready", 32'(bus8.in_ready), 32'h02);
        tick();
        check("ms_fixed_out_sel", 32'(bus8.out_sel), 1);
        check("ms_fixed_out_data", 32'(bus8.out_data), 32'h2345);
        bus8.mode = 1'b1;
        #1;
        check("ms_rr_in_ready", 32'(bus8.in_ready), 32'h10);
        tick();
        check("ms_rr_out_sel", 32'(bus8.out_sel), 4);
        check("ms_rr_out_data", 32'(bus8.out_data), 32'h5678);

        // Five-way: out-of-range select never grants
        bus5.in_valid = 5'h1F; bus5.out_ready = 1'b1; bus5.mode = 1'b0; bus5.sel = 3'd6;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("w5_oor_in_ready", 32'(bus5.in_ready), 0);
            tick();
            check("w5_oor_out_valid", 32'(bus5.out_valid), 0);
        end
        // Five-way round-robin wraps 4 -> 0
        bus5.mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("w5_rr_out_sel", 32'(bus5.out_sel), 32'(w5_tbl[i]));
            check("w5_rr_out_data", 32'(bus5.out_data), 32'(16'hA000 + 16'(w5_tbl[i])));
        end
        bus5.in_valid = '0;

        // Randomized traffic against the reference model
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_vld = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
        for (int c = 0; c < 300; c++) begin
            bus8.in_valid = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus8.mode = ~bus8.mode;
            bus8.sel = 3'($urandom);
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) bus8.in_data[i*16 +: 16] = 16'($urandom);
            g  = pick(bus8.in_valid, bus8.mode, int'(bus8.sel), m_ptr, 8);
            fr = !m_vld || bus8.out_ready;
            exp_rdy = (fr && g >= 0) ? (8'(1) << g) : 8'h00;
            #1;
            check("rnd_in_ready", 32'(bus8.in_ready), 32'(exp_rdy));
            if (fr && g >= 0) begin
                m_data = bus8.in_data[g*16 +: 16];
                m_sel  = g;
                m_vld  = 1'b1;
                if (bus8.mode) m_ptr = (g + 1) % 8;
            end else if (m_vld && bus8.out_ready) begin
                m_vld = 1'b0;
            end
            tick();
            check("rnd_out_valid", 32'(bus8.out_valid), 32'(m_vld));
            check("rnd_out_sel", 32'(bus8.out_sel), 32'(m_sel));
            check("rnd_out_data", 32'(bus8.out_data), 32'(m_data));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
